// File: rtl/verinject_check_pkg.sv
// Shared types for the golden/injected divergence checker.
package verinject_check_pkg;

  typedef enum logic [1:0] {
    CLEAN     = 2'd0,
    RECOVERED = 2'd1,
    FAILED    = 2'd2
  } verdict_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic verdict_t pick_verdict(input logic any_mismatch, input logic settled);
    if (!any_mismatch)
      return CLEAN;
    else if (settled)
      return RECOVERED;
    else
      return FAILED;
  endfunction

endpackage

// File: rtl/verinject_sat_counter.sv
// Up-counter that stops at a programmable ceiling; clr has priority over inc.
module verinject_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != max))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/verinject_divergence_checker.sv
// Compares golden vs injected outputs over a fixed sample window and grades the injection.
//   state | meaning
//   IDLE  | waiting for arm; results from the last window remain readable
//   WATCH | one compare sample per clock until WINDOW samples are taken
//   DONE  | verdict valid and held until arm or clear
module verinject_divergence_checker
  import verinject_check_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int CYCLE_W = 48,
  parameter int WINDOW  = 256,
  parameter int SETTLE  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               clear,
  input  logic [WIDTH-1:0]   golden,
  input  logic [WIDTH-1:0]   injected,
  input  logic [CYCLE_W-1:0] cycle_number,
  output logic               busy,
  output logic               done,
  output logic [1:0]         verdict,
  output logic               diverged,
  output logic [CYCLE_W-1:0] first_cycle,
  output logic [WIDTH-1:0]   first_syndrome,
  output logic [CNT_W-1:0]   mismatch_count
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int RUN_W = $clog2(SETTLE + 1);

  state_t           state;
  verdict_t         verdict_q;
  logic [WIN_W-1:0] win_count;
  logic [RUN_W-1:0] run_count;

  logic mismatch, watching, start, last_sample, settled, any_mismatch;

  assign mismatch    = (golden != injected);
  assign watching    = (state == WATCH);
  assign start       = arm && !clear && (state != WATCH);
  assign last_sample = watching && (win_count == WIN_W'(WINDOW - 1));
  // The verdict must include the sample taken on the same edge, so look one step ahead.
  assign settled      = !mismatch && (run_count >= RUN_W'(SETTLE - 1));
  assign any_mismatch = mismatch || (mismatch_count != '0);
  assign verdict      = verdict_q;

  verinject_sat_counter #(.W(WIN_W)) u_window (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (watching),
    .clr     (start || clear),
    .max     (WIN_W'(WINDOW)),
    .count   (win_count)
  );

  verinject_sat_counter #(.W(RUN_W)) u_match_run (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (watching && !mismatch),
    .clr     (start || clear || (watching && mismatch)),
    .max     (RUN_W'(SETTLE)),
    .count   (run_count)
  );

  // Not cleared by clear so the count stays available for readout.
  verinject_sat_counter #(.W(CNT_W)) u_mismatch (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (watching && mismatch),
    .clr     (start),
    .max     ({CNT_W{1'b1}}),
    .count   (mismatch_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      verdict_q      <= CLEAN;
      diverged       <= 1'b0;
      first_cycle    <= '0;
      first_syndrome <= '0;
    end else if (clear) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      verdict_q <= CLEAN;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state          <= WATCH;
            busy           <= 1'b1;
            done           <= 1'b0;
            verdict_q      <= CLEAN;
            diverged       <= 1'b0;
            first_cycle    <= '0;
            first_syndrome <= '0;
          end
        end
        WATCH: begin
          if (mismatch && !diverged) begin
            diverged       <= 1'b1;
            first_cycle    <= cycle_number;
            first_syndrome <= golden ^ injected;
          end
          if (last_sample) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            verdict_q <= pick_verdict(any_mismatch, settled);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_verinject_divergence_checker.sv
// Directed bench: two checker instances (default and a small-counter variant) with a result scoreboard.
module tb_verinject_divergence_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm1 = 1'b0;
  logic        arm2 = 1'b0;
  logic        clear = 1'b0;
  logic [39:0] golden = '0;
  logic [39:0] injected = '0;
  logic [47:0] cycle_number = '0;

  logic        a_busy, a_done, a_diverged;
  logic [1:0]  a_verdict;
  logic [47:0] a_first_cycle;
  logic [39:0] a_first_syndrome;
  logic [15:0] a_count;

  logic        b_busy, b_done, b_diverged;
  logic [1:0]  b_verdict;
  logic [47:0] b_first_cycle;
  logic [39:0] b_first_syndrome;
  logic [3:0]  b_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  verdict;
    logic [15:0] count;
    logic        diverged;
    logic [47:0] first_cycle;
    logic [39:0] syn;
  } exp_t;

  exp_t sb[$];

  verinject_divergence_checker #(
    .WIDTH(40), .CYCLE_W(48), .WINDOW(256), .SETTLE(16), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .arm(arm1), .clear(clear),
    .golden(golden), .injected(injected), .cycle_number(cycle_number),
    .busy(a_busy), .done(a_done), .verdict(a_verdict), .diverged(a_diverged),
    .first_cycle(a_first_cycle), .first_syndrome(a_first_syndrome),
    .mismatch_count(a_count)
  );

  verinject_divergence_checker #(
    .WIDTH(40), .CYCLE_W(48), .WINDOW(32), .SETTLE(4), .CNT_W(4)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .arm(arm2), .clear(clear),
    .golden(golden), .injected(injected), .cycle_number(cycle_number),
    .busy(b_busy), .done(b_done), .verdict(b_verdict), .diverged(b_diverged),
    .first_cycle(b_first_cycle), .first_syndrome(b_first_syndrome),
    .mismatch_count(b_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sample(input int s, input int lo, input int hi,
                              input logic [39:0] syn, input int base);
    golden       = 40'({$urandom(), $urandom()});
    injected     = (s >= lo && s <= hi) ? (golden ^ syn) : golden;
    cycle_number = 48'(base + s);
  endtask

  // Runs one full window on instance sel; mismatching samples are lo..hi (none if lo < 0).
  task automatic run_window(input int sel, input int lo, input int hi,
                            input logic [39:0] syn, input int base, input bit arm_mid);
    exp_t e;
    int   win, settle, cmax, n, trailing;
    win    = sel ? 32 : 256;
    settle = sel ? 4 : 16;
    cmax   = sel ? 15 : 65535;
    if (lo < 0) begin
      e.verdict = 2'd0; e.count = '0; e.diverged = 1'b0; e.first_cycle = '0; e.syn = '0;
    end else begin
      trailing      = win - 1 - hi;
      e.count       = 16'(((hi - lo + 1) > cmax) ? cmax : (hi - lo + 1));
      e.verdict     = (trailing >= settle) ? 2'd1 : 2'd2;
      e.diverged    = 1'b1;
      e.first_cycle = 48'(base + lo);
      e.syn         = syn;
    end
    sb.push_back(e);

    @(negedge clock);
    if (sel != 0) arm2 = 1'b1; else arm1 = 1'b1;
    drive_sample(0, lo, hi, syn, base);
    @(negedge clock);
    arm1 = 1'b0; arm2 = 1'b0;
    check("busy_after_arm", 64'(sel ? b_busy : a_busy), 64'd1);
    for (int s = 0; s < win; s++) begin
      drive_sample(s, lo, hi, syn, base);
      if (arm_mid && s == win / 2) begin
        if (sel != 0) arm2 = 1'b1; else arm1 = 1'b1;
      end else begin
        arm1 = 1'b0; arm2 = 1'b0;
      end
      @(negedge clock);
    end
    arm1 = 1'b0; arm2 = 1'b0;
    injected = golden;

    n = 0;
    while (!(sel ? b_done : a_done) && n < 8) begin
      @(negedge clock);
      n++;
    end
    check("done_latency", 64'(n), 64'd0);
    check("busy_at_done", 64'(sel ? b_busy : a_busy), 64'd0);

    e = sb.pop_front();
    check("verdict",        64'(sel ? b_verdict : a_verdict), 64'(e.verdict));
    check("mismatch_count", 64'(sel ? 16'(b_count) : a_count), 64'(e.count));
    check("diverged",       64'(sel ? b_diverged : a_diverged), 64'(e.diverged));
    check("first_cycle",    64'(sel ? b_first_cycle : a_first_cycle), 64'(e.first_cycle));
    check("first_syndrome", 64'(sel ? b_first_syndrome : a_first_syndrome), 64'(e.syn));
  endtask

  initial begin
    bit done_seen;

    repeat (2) @(negedge clock);
    check("reset_busy",    64'(a_busy), 64'd0);
    check("reset_done",    64'(a_done), 64'd0);
    check("reset_verdict", 64'(a_verdict), 64'd0);
    check("reset_count",   64'(a_count), 64'd0);
    check("reset_div",     64'(a_diverged), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // clean window, with an arm pulse mid-window that must be ignored
    run_window(0, -1, -2, 40'h0, 0, 1'b1);
    // single bit flip in sum[3] at cycle 40
    run_window(0, 40, 40, 40'h0000000008, 0, 1'b0);
    // persistent mismatch from cycle 100 to window end
    run_window(0, 100, 255, 40'h0100000000, 0, 1'b0);
    // mismatch ending 10 samples before end -> FAILED
    run_window(0, 200, 245, 40'h00000000F0, 0, 1'b0);
    // boundary: 15 trailing matches -> FAILED, 16 -> RECOVERED
    run_window(0, 200, 240, 40'h0000010000, 0, 1'b0);
    run_window(0, 200, 239, 40'h0000010000, 0, 1'b0);

    // done held, then clear keeps readout but drops busy/done/verdict
    repeat (3) @(negedge clock);
    check("done_held", 64'(a_done), 64'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_done",    64'(a_done), 64'd0);
    check("clear_busy",    64'(a_busy), 64'd0);
    check("clear_verdict", 64'(a_verdict), 64'd0);
    check("clear_count",   64'(a_count), 64'd40);
    check("clear_div",     64'(a_diverged), 64'd1);
    check("clear_first",   64'(a_first_cycle), 64'd200);

    // small counter instance: 20 mismatches saturate a 4-bit count
    run_window(1, 0, 19, 40'hA500000001, 1000, 1'b0);

    // clear together with arm mid-window: clear wins, no done afterwards
    @(negedge clock);
    arm1 = 1'b1;
    @(negedge clock);
    arm1 = 1'b0;
    for (int s = 0; s < 50; s++) begin
      drive_sample(s, 10, 60, 40'h3, 0);
      @(negedge clock);
    end
    clear = 1'b1; arm1 = 1'b1;
    @(negedge clock);
    clear = 1'b0; arm1 = 1'b0;
    check("clrarm_busy", 64'(a_busy), 64'd0);
    check("clrarm_done", 64'(a_done), 64'd0);
    done_seen = 1'b0;
    for (int s = 0; s < 270; s++) begin
      drive_sample(s, 0, 300, 40'h1, 0);
      @(negedge clock);
      if (a_done || a_busy) done_seen = 1'b1;
    end
    check("clrarm_no_done", 64'(done_seen), 64'd0);

    // reset mid-window: immediate return to reset values, no verdict later
    injected = golden;
    @(negedge clock);
    arm1 = 1'b1;
    @(negedge clock);
    arm1 = 1'b0;
    for (int s = 0; s < 30; s++) begin
      drive_sample(s, 5, 29, 40'h80, 0);
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    check("rst_busy",  64'(a_busy), 64'd0);
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_div",   64'(a_diverged), 64'd0);
    check("rst_first", 64'(a_first_cycle), 64'd0);
    check("rst_syn",   64'(a_first_syndrome), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    done_seen = 1'b0;
    for (int s = 0; s < 270; s++) begin
      drive_sample(s, 0, 300, 40'h2, 0);
      @(negedge clock);
      if (a_done || a_busy) done_seen = 1'b1;
    end
    check("rst_no_done", 64'(done_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/verinject_divergence_checker.md
# verinject_divergence_checker

Cycle-accurate comparator sitting downstream of a golden/injected design pair (`top` and `top__injected`). It consumes both output vectors plus the `cycle_number` from `verinject_file_tester`, and records the first divergence: its cycle and XOR syndrome. It counts mismatching cycles over a fixed observation window and issues a per-injection verdict (CLEAN / RECOVERED / FAILED). This replaces ad-hoc per-signal `$display` comparison with synthesizable, countable results usable in campaigns.

## Interface
- `WIDTH`, 40: compared vector width (e.g. `{index[7:0], sum[31:0]}`).
- `CYCLE_W`, 48: width of `cycle_number`.
- `WINDOW`, 256: number of sampled cycles per observation window; must be ≥ 1.
- `SETTLE`, 16: trailing consecutive matching samples required for RECOVERED; 1 ≤ `SETTLE` ≤ `WINDOW`.
- `CNT_W`, 16: mismatch counter width.

Ports:
- `clock` in 1: single clock; all sampling on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `arm` in 1: pulse; starts a window.
- `clear` in 1: synchronous; abort and return to IDLE.
- `golden` in WIDTH: reference design outputs.
- `injected` in WIDTH: injected design outputs.
- `cycle_number` in CYCLE_W: current cycle from the injector.
- `busy` out 1: window in progress.
- `done` out 1: verdict valid; held until `arm` or `clear`.
- `verdict` out 2: 0 CLEAN, 1 RECOVERED, 2 FAILED, 3 never driven.
- `diverged` out 1: at least one mismatch seen in the current window.
- `first_cycle` out CYCLE_W: `cycle_number` at the first mismatching sample.
- `first_syndrome` out WIDTH: `golden ^ injected` at the first mismatching sample.
- `mismatch_count` out CNT_W: mismatching samples, saturating at all-ones.

## Operation
- States: IDLE, WATCH, DONE.
- IDLE: `arm` → WATCH. All counters, `diverged`, `first_*` and `verdict` are zeroed on entry to WATCH.
- WATCH: one sample per clock. A sample mismatches iff `golden != injected`, bitwise over all WIDTH bits.
  - First mismatch: set `diverged`; latch `first_cycle` and `first_syndrome`. Later mismatches never overwrite them.
  - Each mismatch: `mismatch_count` += 1, saturating; match-run counter reset to 0.
  - Each match: match-run counter += 1, saturating at `SETTLE`.
  - The window counter counts samples. After the `WINDOW`-th sample, go to DONE.
- Verdict, computed from state including the final sample:
  - `mismatch_count == 0` → CLEAN.
  - else match-run == `SETTLE` → RECOVERED.
  - else → FAILED.
- DONE: `done` = 1 and all results are held.
  - `arm` → WATCH, clearing the results.
  - `arm` while in WATCH is ignored.
- `clear` from any state → IDLE. `busy`, `done` and `verdict` go to 0. `first_*`, `mismatch_count` and `diverged` are retained for readout.
- `clear` and `arm` in the same cycle: `clear` wins.

## Timing
- Reset values: state IDLE; all outputs 0.
- `arm` sampled high at edge N: `busy` = 1 after edge N. The first compare sample is taken at edge N+1.
- The sample at edge k is reflected in `diverged`, `first_*` and `mismatch_count` after edge k; they are registered, with one-edge latency.
- The last sample is taken at edge N+WINDOW. After that edge: `busy` = 0, `done` = 1, and `verdict` is valid in the same cycle.
- Reset asserted mid-window: immediate return to reset values. No partial verdict is produced.
- `golden` and `injected` must be stable at the rising edge. Drive the design pair from the same `clock`.
- `cycle_number` wrap-around is not special-cased; the value is latched as-is.

## Structure
- Package `verinject_check_pkg`:
  - `verdict_t` enum: CLEAN=2'd0, RECOVERED=2'd1, FAILED=2'd2.
  - `state_t` enum: IDLE, WATCH, DONE.
- Sub-module `verinject_sat_counter` (parameter W; ports `inc`, `clr`, `count`, `max`), instantiated three times:
  - window counter;
  - match-run counter, with its saturation value set to `SETTLE`;
  - mismatch counter.
- Everything else lives in the top FSM.

## Test plan
- Identical vectors, `WINDOW`=256: `arm` → `done` after 256 samples, `verdict`=0, `mismatch_count`=0, `diverged`=0.
- Single bit flip in injected `sum` bit 3 at cycle 40 only: `first_cycle`=40, `first_syndrome`=40'h0000000008, `mismatch_count`=1, `verdict`=1.
- Persistent mismatch from cycle 100 to end of window: `verdict`=2, `mismatch_count` = samples from 100 to the window end, and `first_cycle`=100.
- Mismatch ending 10 samples before window end with `SETTLE`=16: `verdict`=2. Ending exactly 16 samples before: `verdict`=1 (boundary).
- `CNT_W`=4 with 20 mismatches: `mismatch_count`=4'hF.
- `clear` asserted together with `arm` mid-window, then `reset_n` low mid-window: state IDLE, `busy`=0, and no `done` pulse.
